// File: rtl/gcm_sequencer_if.sv
// Command and block-stream handshake bundle between a message source and gcm_sequencer.
interface gcm_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [95:0]      cmd_iv;
    logic [127:0]     cmd_key;
    logic [CNT_W-1:0] cmd_aad_blocks;
    logic [CNT_W-1:0] cmd_pt_blocks;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;

    modport master (
        output cmd_valid, cmd_iv, cmd_key, cmd_aad_blocks, cmd_pt_blocks, in_valid, in_data,
        input  cmd_ready, in_ready
    );

    modport slave (
        input  cmd_valid, cmd_iv, cmd_key, cmd_aad_blocks, cmd_pt_blocks, in_valid, in_data,
        output cmd_ready, in_ready
    );
endinterface

// File: rtl/gcm_sequencer.sv
// Sequences one GCM message (AAD blocks, then PT blocks) into a fixed-latency AES-GCM pipeline,
// tracks ciphertext emergence and waits, with a timeout, for the final tag.
module gcm_sequencer #(
    parameter int unsigned LATENCY     = 9,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TAG_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    gcm_sequencer_if.slave bus,
    output logic           p_new_instance,
    output logic           p_pt_instance,
    output logic           p_block_valid,
    output logic [95:0]    p_iv,
    output logic [127:0]   p_key,
    output logic [127:0]   p_plain_text,
    output logic [127:0]   p_aad,
    output logic [63:0]    p_aad_size,
    output logic [63:0]    p_plain_text_size,
    input  logic [127:0]   p_cipher_text,
    input  logic [127:0]   p_tag,
    input  logic           p_tag_ready,
    output logic           ct_valid,
    output logic [127:0]   ct_data,
    output logic           tag_valid,
    output logic [127:0]   tag,
    output logic           busy,
    output logic           err
);
    localparam int unsigned TimeoutCycles = LATENCY + TAG_TIMEOUT;

    typedef enum logic [2:0] {StIdle, StAad, StPt, StEmpty, StWaitTag} state_e;

    state_e             state_q;
    logic [95:0]        iv_q;
    logic [127:0]       key_q;
    logic [CNT_W-1:0]   aad_blocks_q, pt_blocks_q, aad_rem_q, pt_rem_q;
    logic               first_q;
    logic               new_inst_q, pt_inst_q, blk_valid_q;
    logic [127:0]       pt_data_q, aad_data_q;
    logic [31:0]        wait_cnt_q;
    logic               tag_valid_q, err_q;
    logic [127:0]       tag_q;
    logic [LATENCY-1:0] ct_sr_q;
    logic               cmd_hs, in_hs;

    // Hold off a new command for the cycle in which tag_valid or err is presented.
    assign bus.cmd_ready = (state_q == StIdle) & ~tag_valid_q & ~err_q;
    assign bus.in_ready  = (state_q == StAad) | (state_q == StPt);
    assign cmd_hs        = bus.cmd_valid & bus.cmd_ready;
    assign in_hs         = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            iv_q         <= '0;
            key_q        <= '0;
            aad_blocks_q <= '0;
            pt_blocks_q  <= '0;
            aad_rem_q    <= '0;
            pt_rem_q     <= '0;
            first_q      <= 1'b0;
            new_inst_q   <= 1'b0;
            pt_inst_q    <= 1'b0;
            blk_valid_q  <= 1'b0;
            pt_data_q    <= '0;
            aad_data_q   <= '0;
            wait_cnt_q   <= '0;
            tag_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            tag_q        <= '0;
            ct_sr_q      <= '0;
        end else begin
            new_inst_q  <= 1'b0;
            pt_inst_q   <= 1'b0;
            blk_valid_q <= 1'b0;
            pt_data_q   <= '0;
            aad_data_q  <= '0;
            tag_valid_q <= 1'b0;
            err_q       <= 1'b0;
            tag_q       <= '0;
            wait_cnt_q  <= '0;

            unique case (state_q)
                StIdle: begin
                    if (cmd_hs) begin
                        iv_q         <= bus.cmd_iv;
                        key_q        <= bus.cmd_key;
                        aad_blocks_q <= bus.cmd_aad_blocks;
                        pt_blocks_q  <= bus.cmd_pt_blocks;
                        aad_rem_q    <= bus.cmd_aad_blocks;
                        pt_rem_q     <= bus.cmd_pt_blocks;
                        first_q      <= 1'b1;
                        if (bus.cmd_aad_blocks != '0) begin
                            state_q <= StAad;
                        end else if (bus.cmd_pt_blocks != '0) begin
                            state_q <= StPt;
                        end else begin
                            // Zero-length message: the single empty issue happens during StEmpty.
                            state_q     <= StEmpty;
                            new_inst_q  <= 1'b1;
                            blk_valid_q <= 1'b1;
                            first_q     <= 1'b0;
                        end
                    end
                end
                StAad: begin
                    if (in_hs) begin
                        blk_valid_q <= 1'b1;
                        new_inst_q  <= first_q;
                        first_q     <= 1'b0;
                        aad_data_q  <= bus.in_data;
                        aad_rem_q   <= aad_rem_q - CNT_W'(1);
                        if (aad_rem_q == CNT_W'(1)) begin
                            state_q <= (pt_blocks_q != '0) ? StPt : StWaitTag;
                        end
                    end
                end
                StPt: begin
                    if (in_hs) begin
                        blk_valid_q <= 1'b1;
                        pt_inst_q   <= 1'b1;
                        new_inst_q  <= first_q;
                        first_q     <= 1'b0;
                        pt_data_q   <= bus.in_data;
                        pt_rem_q    <= pt_rem_q - CNT_W'(1);
                        if (pt_rem_q == CNT_W'(1)) begin
                            state_q <= StWaitTag;
                        end
                    end
                end
                StEmpty: begin
                    state_q <= StWaitTag;
                end
                StWaitTag: begin
                    if (p_tag_ready) begin
                        tag_valid_q <= 1'b1;
                        tag_q       <= p_tag;
                        state_q     <= StIdle;
                    end else if (wait_cnt_q == 32'(TimeoutCycles - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Ciphertext emerges LATENCY cycles after each issued PT block.
            ct_sr_q[0] <= pt_inst_q & blk_valid_q;
            for (int i = 1; i < int'(LATENCY); i++) begin
                ct_sr_q[i] <= ct_sr_q[i-1];
            end
        end
    end

    assign p_new_instance    = new_inst_q;
    assign p_pt_instance     = pt_inst_q;
    assign p_block_valid     = blk_valid_q;
    assign p_iv              = iv_q;
    assign p_key             = key_q;
    assign p_plain_text      = pt_data_q;
    assign p_aad             = aad_data_q;
    assign p_aad_size        = {{(57 - CNT_W){1'b0}}, aad_blocks_q, 7'b0};
    assign p_plain_text_size = {{(57 - CNT_W){1'b0}}, pt_blocks_q, 7'b0};
    assign ct_valid          = ct_sr_q[LATENCY-1];
    assign ct_data           = ct_valid ? p_cipher_text : '0;
    assign tag_valid         = tag_valid_q;
    assign tag               = tag_q;
    assign busy              = (state_q != StIdle);
    assign err               = err_q;
endmodule

// File: tb/tb_gcm_sequencer.sv
// Directed bench for gcm_sequencer: normal, empty, gapped, timeout, reset-abort and size cases.
module tb_gcm_sequencer;
    localparam logic [95:0] CT_HI = 96'hC1FE_0000_0000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         p_new_instance, p_pt_instance, p_block_valid;
    logic [95:0]  p_iv;
    logic [127:0] p_key, p_plain_text, p_aad;
    logic [63:0]  p_aad_size, p_plain_text_size;
    logic [127:0] p_cipher_text;
    logic [127:0] p_tag = '0;
    logic         p_tag_ready = 1'b0;
    logic         ct_valid, tag_valid, busy, err;
    logic [127:0] ct_data, tag;
    logic [31:0]  cyc = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  issue_cyc[$];
    logic         issue_new[$];
    logic         issue_pt[$];
    logic [127:0] issue_aad[$];
    logic [127:0] issue_ptd[$];
    logic [31:0]  ct_cyc[$];
    logic [127:0] ct_dat[$];
    int           tag_cnt, err_cnt, n_accept;

    gcm_sequencer_if #(.CNT_W(16)) bus ();

    gcm_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .p_new_instance    (p_new_instance),
        .p_pt_instance     (p_pt_instance),
        .p_block_valid     (p_block_valid),
        .p_iv              (p_iv),
        .p_key             (p_key),
        .p_plain_text      (p_plain_text),
        .p_aad             (p_aad),
        .p_aad_size        (p_aad_size),
        .p_plain_text_size (p_plain_text_size),
        .p_cipher_text     (p_cipher_text),
        .p_tag             (p_tag),
        .p_tag_ready       (p_tag_ready),
        .ct_valid          (ct_valid),
        .ct_data           (ct_data),
        .tag_valid         (tag_valid),
        .tag               (tag),
        .busy              (busy),
        .err               (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Pipeline result tagged with the current cycle so ct_data can be traced back.
    assign p_cipher_text = {CT_HI, cyc};

    always @(negedge clk) begin
        if (!rst) begin
            if (p_block_valid) begin
                issue_cyc.push_back(cyc);
                issue_new.push_back(p_new_instance);
                issue_pt.push_back(p_pt_instance);
                issue_aad.push_back(p_aad);
                issue_ptd.push_back(p_plain_text);
            end
            if (ct_valid) begin
                ct_cyc.push_back(cyc);
                ct_dat.push_back(ct_data);
            end
            if (tag_valid) tag_cnt++;
            if (err) err_cnt++;
            if (bus.cmd_valid && bus.cmd_ready) n_accept++;
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_logs();
        issue_cyc.delete();
        issue_new.delete();
        issue_pt.delete();
        issue_aad.delete();
        issue_ptd.delete();
        ct_cyc.delete();
        ct_dat.delete();
        tag_cnt  = 0;
        err_cnt  = 0;
        n_accept = 0;
    endtask

    task automatic send_cmd(input logic [15:0] aad, input logic [15:0] pt, input logic [95:0] iv,
                            input logic [127:0] key, input bit hold);
        int g;
        bus.cmd_valid      = 1'b1;
        bus.cmd_aad_blocks = aad;
        bus.cmd_pt_blocks  = pt;
        bus.cmd_iv         = iv;
        bus.cmd_key        = key;
        g = 0;
        @(negedge clk);
        while (!bus.cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!bus.cmd_ready) check("cmd_ready_wait", 128'(bus.cmd_ready), 128'(1));
        @(posedge clk);
        #1;
        if (!hold) bus.cmd_valid = 1'b0;
    endtask

    task automatic push_block(input logic [127:0] d);
        int g;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!bus.in_ready) check("in_ready_wait", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic give_tag(input logic [127:0] t);
        p_tag       = t;
        p_tag_ready = 1'b1;
        @(posedge clk);
        #1;
        p_tag_ready = 1'b0;
        p_tag       = '0;
        check("tag_valid", 128'(tag_valid), 128'(1));
        check("tag_value", tag, t);
        check("cmd_ready_at_tag", 128'(bus.cmd_ready), 128'(0));
        check("busy_at_tag", 128'(busy), 128'(0));
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("cmd_ready_after_tag", 128'(bus.cmd_ready), 128'(1));
        check("tag_valid_pulse", 128'(tag_valid), 128'(0));
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] entry;
        int g;
        bus.cmd_valid      = 1'b0;
        bus.cmd_iv         = '0;
        bus.cmd_key        = '0;
        bus.cmd_aad_blocks = '0;
        bus.cmd_pt_blocks  = '0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        clear_logs();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1));
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_blk_valid", 128'(p_block_valid), 128'(0));
        check("rst_outs", 128'({ct_valid, tag_valid, err, p_new_instance}), 128'(0));
        check("rst_aad_size", 128'(p_aad_size), 128'(0));
        check("rst_ct_data", ct_data, 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // aad=1, pt=2 back to back, cmd_valid held through the message
        clear_logs();
        send_cmd(16'd1, 16'd2, 96'hA1A1_0000_1111_2222_3333_4444, 128'hC0FFEE, 1'b1);
        check("a_busy", 128'(busy), 128'(1));
        check("a_cmd_ready", 128'(bus.cmd_ready), 128'(0));
        check("a_aad_size", 128'(p_aad_size), 128'(128));
        check("a_pt_size", 128'(p_plain_text_size), 128'(256));
        check("a_iv", 128'(p_iv), 128'(96'hA1A1_0000_1111_2222_3333_4444));
        check("a_key", p_key, 128'hC0FFEE);
        push_block(128'hAAD0);
        push_block(128'h1111_0001);
        push_block(128'h1111_0002);
        bus.in_valid = 1'b0;
        idle_cycles(12);
        give_tag(128'hDEAD_BEEF_000A);
        check("a_issue_cnt", 128'(issue_cyc.size()), 128'(3));
        check("a_ct_cnt", 128'(ct_cyc.size()), 128'(2));
        check("a_tag_cnt", 128'(tag_cnt), 128'(1));
        check("a_accepts", 128'(n_accept), 128'(1));
        if (issue_cyc.size() == 3) begin
            check("a_new0", 128'(issue_new[0]), 128'(1));
            check("a_pt0", 128'(issue_pt[0]), 128'(0));
            check("a_aad0", issue_aad[0], 128'hAAD0);
            check("a_ptd0", issue_ptd[0], 128'(0));
            check("a_new1", 128'(issue_new[1]), 128'(0));
            check("a_pt1", 128'(issue_pt[1]), 128'(1));
            check("a_ptd1", issue_ptd[1], 128'h1111_0001);
            check("a_aad1", issue_aad[1], 128'(0));
            check("a_ptd2", issue_ptd[2], 128'h1111_0002);
            check("a_back2back", 128'(issue_cyc[2] - issue_cyc[1]), 128'(1));
            if (ct_cyc.size() == 2) begin
                for (int i = 0; i < 2; i++) begin
                    check("a_ct_lat", 128'(ct_cyc[i] - issue_cyc[i+1]), 128'(9));
                    check("a_ct_data", ct_dat[i], {CT_HI, ct_cyc[i]});
                end
            end
        end

        // Zero-length message
        clear_logs();
        send_cmd(16'd0, 16'd0, 96'hB2, 128'hB2B2, 1'b0);
        check("b_aad_size", 128'(p_aad_size), 128'(0));
        check("b_pt_size", 128'(p_plain_text_size), 128'(0));
        idle_cycles(12);
        give_tag(128'h7A6_000B);
        check("b_issue_cnt", 128'(issue_cyc.size()), 128'(1));
        if (issue_cyc.size() == 1) begin
            check("b_new", 128'(issue_new[0]), 128'(1));
            check("b_pt", 128'(issue_pt[0]), 128'(0));
            check("b_data", issue_aad[0] | issue_ptd[0], 128'(0));
        end
        check("b_ct_cnt", 128'(ct_cyc.size()), 128'(0));
        check("b_tag_cnt", 128'(tag_cnt), 128'(1));

        // pt=3 with a two-cycle gap after the first block; stray p_tag_ready in the gap
        clear_logs();
        send_cmd(16'd0, 16'd3, 96'hC3, 128'hC3C3, 1'b0);
        push_block(128'h3333_0000);
        bus.in_valid = 1'b0;
        p_tag        = 128'hBAD;
        p_tag_ready  = 1'b1;
        idle_cycles(2);
        p_tag_ready  = 1'b0;
        push_block(128'h3333_0001);
        push_block(128'h3333_0002);
        bus.in_valid = 1'b0;
        idle_cycles(12);
        give_tag(128'h7A6_000C);
        check("c_issue_cnt", 128'(issue_cyc.size()), 128'(3));
        check("c_ct_cnt", 128'(ct_cyc.size()), 128'(3));
        check("c_tag_cnt", 128'(tag_cnt), 128'(1));
        if (issue_cyc.size() == 3 && ct_cyc.size() == 3) begin
            check("c_gap", 128'(issue_cyc[1] - issue_cyc[0]), 128'(3));
            check("c_b2b", 128'(issue_cyc[2] - issue_cyc[1]), 128'(1));
            for (int i = 0; i < 3; i++) begin
                check("c_ct_lat", 128'(ct_cyc[i] - issue_cyc[i]), 128'(9));
            end
            check("c_new0", 128'(issue_new[0]), 128'(1));
            check("c_new1", 128'(issue_new[1]), 128'(0));
        end

        // Tag never arrives: timeout
        clear_logs();
        send_cmd(16'd0, 16'd1, 96'hD4, 128'hD4D4, 1'b0);
        push_block(128'h4444);
        bus.in_valid = 1'b0;
        entry = cyc;
        g = 0;
        @(negedge clk);
        while (!err && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("d_err_seen", 128'(err), 128'(1));
        check("d_err_cycle", 128'(cyc - entry), 128'(25));
        check("d_cmd_ready_at_err", 128'(bus.cmd_ready), 128'(0));
        @(negedge clk);
        check("d_cmd_ready_after", 128'(bus.cmd_ready), 128'(1));
        check("d_err_pulse", 128'(err), 128'(0));
        check("d_tag_cnt", 128'(tag_cnt), 128'(0));
        check("d_err_cnt", 128'(err_cnt), 128'(1));

        // Reset during PT block 2 of 4
        clear_logs();
        @(posedge clk);
        #1;
        send_cmd(16'd0, 16'd4, 96'hE5, 128'hE5E5, 1'b0);
        push_block(128'h5555_0000);
        push_block(128'h5555_0001);
        rst = 1'b1;
        #1;
        check("e_blk_valid", 128'(p_block_valid), 128'(0));
        check("e_pt_inst", 128'(p_pt_instance), 128'(0));
        check("e_busy", 128'(busy), 128'(0));
        check("e_cmd_ready", 128'(bus.cmd_ready), 128'(1));
        check("e_pt_size", 128'(p_plain_text_size), 128'(0));
        check("e_iv", 128'(p_iv), 128'(0));
        bus.in_valid = 1'b0;
        clear_logs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(30);
        check("e_no_ct", 128'(ct_cyc.size()), 128'(0));
        check("e_no_tag", 128'(tag_cnt), 128'(0));
        check("e_no_err", 128'(err_cnt), 128'(0));

        // Max AAD count size; fresh command after reset; held cmd_valid accepted once
        clear_logs();
        send_cmd(16'd65535, 16'd0, 96'hF6F6_0000_0000_0000_0000_0001, 128'hF6, 1'b1);
        check("f_aad_size", 128'(p_aad_size), 128'(8388480));
        check("f_pt_size", 128'(p_plain_text_size), 128'(0));
        check("f_iv", 128'(p_iv), 128'(96'hF6F6_0000_0000_0000_0000_0001));
        push_block(128'h6666);
        bus.in_valid = 1'b0;
        idle_cycles(3);
        check("f_aad_size_hold", 128'(p_aad_size), 128'(8388480));
        check("f_accepts", 128'(n_accept), 128'(1));
        check("f_issue_cnt", 128'(issue_cyc.size()), 128'(1));
        if (issue_cyc.size() == 1) check("f_new", 128'(issue_new[0]), 128'(1));
        bus.cmd_valid = 1'b0;
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gcm_sequencer.md
GCM_SEQUENCER -- requirements
Module: gcm_sequencer

Interface
Parameters:
REQ-001 SHALL have parameter LATENCY, default 9, cycles from pipeline block issue to matching o_cipher_text.
REQ-002 SHALL have parameter CNT_W, default 16, width of block counters.
REQ-003 SHALL have parameter TAG_TIMEOUT, default 16, cycles allowed after LATENCY for tag arrival.

Ports:
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  message command handshake.
REQ-007 cmd_iv  in  96  message IV.
REQ-008 cmd_key  in  128  cipher key.
REQ-009 cmd_aad_blocks / cmd_pt_blocks  in  CNT_W each  AAD and plaintext block counts.
REQ-010 in_valid / in_ready / in_data  in / out / in  1 / 1 / 128  block stream: all AAD blocks, then all PT blocks.
REQ-011 p_new_instance, p_pt_instance, p_block_valid  out  1 each  pipeline controls.
REQ-012 p_iv / p_key  out  96 / 128  pipeline IV and key.
REQ-013 p_plain_text / p_aad  out  128 each  pipeline data.
REQ-014 p_aad_size / p_plain_text_size  out  64 each  pipeline sizes.
REQ-015 p_cipher_text / p_tag / p_tag_ready  in  128 / 128 / 1  pipeline results.
REQ-016 ct_valid / ct_data  out  1 / 128  ciphertext out; no backpressure.
REQ-017 tag_valid / tag  out  1 / 128  final tag.
REQ-018 busy / err  out  1 / 1  message in flight / timeout pulse.

Function
REQ-019 SHALL implement states IDLE, AAD, PT, EMPTY, WAIT_TAG.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a cmd handshake SHALL latch iv, key and counts and set busy=1 the next cycle.
REQ-021 On accept, next state SHALL be AAD if aad_blocks>0, else PT if pt_blocks>0, else EMPTY.
REQ-022 in_ready SHALL be 1 only in AAD or PT.
REQ-023 Each in handshake SHALL issue one pipeline block the next cycle with p_block_valid=1; cycles without a handshake SHALL issue p_block_valid=0, p_new_instance=0, p_pt_instance=0.
REQ-024 AAD blocks SHALL drive p_aad=in_data, p_plain_text=0, p_pt_instance=0; PT blocks SHALL drive p_plain_text=in_data, p_aad=0, p_pt_instance=1.
REQ-025 p_new_instance SHALL be 1 on the first issued block of a message only.
REQ-026 EMPTY (zero-length message) SHALL issue one cycle with p_new_instance=1, p_block_valid=1, zero data, then go to WAIT_TAG.
REQ-027 p_aad_size = aad_blocks*128 and p_plain_text_size = pt_blocks*128, zero-extended to 64 bits; these and p_iv/p_key SHALL hold stable from accept until return to IDLE.
REQ-028 AAD SHALL move to PT (or WAIT_TAG if pt_blocks=0) on the handshake of the last AAD block; PT SHALL move to WAIT_TAG on the last PT block.
REQ-029 A LATENCY-deep shift register of issued p_pt_instance&p_block_valid SHALL produce ct_valid; ct_data = p_cipher_text when ct_valid, else 0.
REQ-030 WAIT_TAG SHALL count cycles from entry; p_tag_ready=1 SHALL give tag_valid=1 for one cycle with tag=p_tag, then IDLE, busy=0.
REQ-031 If the count reaches LATENCY+TAG_TIMEOUT without p_tag_ready, err SHALL pulse one cycle and the state SHALL return to IDLE.
REQ-032 p_tag_ready outside WAIT_TAG SHALL be ignored.
REQ-033 cmd_ready SHALL stay 0 until the cycle after tag_valid or err.

Reset
REQ-034 rst SHALL force IDLE asynchronously and clear counters, shift register and all outputs to 0, except cmd_ready=1 in IDLE.
REQ-035 rst mid-message SHALL discard the message; no ct_valid, tag_valid or err SHALL follow from it.

Verification
REQ-036 aad=1, pt=2, in_valid always 1 -> p_new_instance on the AAD block; p_pt_instance=1 on the next 2 blocks; ct_valid at issue+9 for 2 cycles; tag_valid once.
REQ-037 aad=0, pt=0 -> one EMPTY issue cycle; sizes 0; tag_valid on p_tag_ready; no ct_valid.
REQ-038 pt=3 with in_valid low for 2 cycles between blocks 1 and 2 -> 2 cycles with p_block_valid=0; ct_valid gaps match exactly.
REQ-039 p_tag_ready never asserted -> err pulse 25 cycles after WAIT_TAG entry; cmd_ready=1 next cycle.
REQ-040 rst asserted during PT block 2 of 4 -> outputs 0 immediately; no ct_valid afterwards; next command starts cleanly.
REQ-041 cmd_valid held during busy -> no second accept until after tag_valid; aad_blocks=65535 gives p_aad_size=8388480.
